// File: rtl/wb_pkg.sv
// Shared constants and mode encodings for the writeback saturate/merge path.
package wb_pkg;

    localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
    localparam logic [31:0] FP_NEG_ONE = 32'hBF80_0000;
    localparam logic [7:0]  FP_EXP_ONE = 8'h7F;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        SAT_NONE  = 2'd0,
        SAT_UNIT  = 2'd1,
        SAT_SNORM = 2'd2,
        SAT_RSVD  = 2'd3
    } sat_mode_e;

endpackage

// File: rtl/wb_sat_lane.sv
// One FP32 lane: saturation by mode, write-mask gating, saturation flag.
module wb_sat_lane
    import wb_pkg::*;
(
    input  logic [31:0] x_i,
    input  logic [1:0]  mode_i,
    input  logic        mask_i,
    output logic [31:0] y_o,
    output logic        sat_o
);

    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic        is_nan;
    logic [31:0] fx;

    assign s      = x_i[31];
    assign e      = x_i[30:23];
    assign m      = x_i[22:0];
    assign is_nan = (e == FP_EXP_MAX) && (m != 23'd0);

    // Saturated value before masking; exponent >= bias means |x| >= 1.0 or Inf.
    always_comb begin
        fx = x_i;
        case (sat_mode_e'(mode_i))
            SAT_UNIT: begin
                if (is_nan || s)         fx = 32'h0;
                else if (e >= FP_EXP_ONE) fx = FP_ONE;
            end
            SAT_SNORM: begin
                if (is_nan)               fx = 32'h0;
                else if (e >= FP_EXP_ONE) fx = s ? FP_NEG_ONE : FP_ONE;
            end
            default: ;
        endcase
    end

    // Masked lanes write zero and never report saturation.
    assign y_o   = mask_i ? fx : 32'h0;
    assign sat_o = mask_i && (fx != x_i);

endmodule

// File: rtl/wb_sat_merge_pipe.sv
// Writeback saturate/merge stage: per-lane saturation, one output register
// with valid/ready handshake, and a saturating count of saturated lanes.
module wb_sat_merge_pipe
    import wb_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_mode,
    input  logic [LANES-1:0]      in_mask,
    input  logic [ADDR_W-1:0]     in_rd,
    input  logic [32*LANES-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*LANES-1:0]   out_data,
    output logic [LANES-1:0]      out_mask,
    output logic [ADDR_W-1:0]     out_rd,
    output logic [LANES-1:0]      out_sat,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      sat_cnt
);

    localparam int PW = $clog2(LANES + 1);

    logic [LANES-1:0][31:0] lane_y;
    logic [LANES-1:0]       lane_sat;
    logic [PW-1:0]          pop;
    logic [CNT_W+PW-1:0]    cnt_sum;
    logic                   accept;

    logic                   valid_q, valid_d;
    logic [32*LANES-1:0]    data_q,  data_d;
    logic [LANES-1:0]       mask_q,  mask_d;
    logic [ADDR_W-1:0]      rd_q,    rd_d;
    logic [LANES-1:0]       sat_q,   sat_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        wb_sat_lane u_lane (
            .x_i    (in_data[32*i +: 32]),
            .mode_i (in_mode),
            .mask_i (in_mask[i]),
            .y_o    (lane_y[i]),
            .sat_o  (lane_sat[i])
        );
    end

    // Register is free when empty or being drained this cycle.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Number of saturated lanes in the incoming beat.
    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) pop = pop + PW'(lane_sat[i]);
    end

    assign cnt_sum = {{PW{1'b0}}, cnt_q} + (CNT_W+PW)'(pop);

    // Next state: load on accept, drop valid on drain, counter saturates.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        mask_d  = mask_q;
        rd_d    = rd_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = lane_y;
            mask_d  = in_mask;
            rd_d    = in_rd;
            sat_d   = lane_sat;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        if (cnt_clr)
            cnt_d = '0;
        else if (accept)
            cnt_d = (cnt_sum[CNT_W+PW-1:CNT_W] != '0) ? '1 : cnt_sum[CNT_W-1:0];
    end

    // Output register and counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            mask_q  <= '0;
            rd_q    <= '0;
            sat_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            rd_q    <= rd_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_mask  = mask_q;
    assign out_rd    = rd_q;
    assign out_sat   = sat_q;
    assign sat_cnt   = cnt_q;

endmodule

// File: tb/tb_wb_sat_merge_pipe.sv
// Scoreboard bench for wb_sat_merge_pipe (LANES=4, CNT_W=4).
module tb_wb_sat_merge_pipe;

    localparam int LANES  = 4;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   mask;
        logic [4:0]   rd;
        logic [3:0]   sat;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          in_mode;
    logic [LANES-1:0]    in_mask;
    logic [ADDR_W-1:0]   in_rd;
    logic [32*LANES-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [32*LANES-1:0] out_data;
    logic [LANES-1:0]    out_mask;
    logic [ADDR_W-1:0]   out_rd;
    logic [LANES-1:0]    out_sat;
    logic                cnt_clr;
    logic [CNT_W-1:0]    sat_cnt;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_popped = 0;
    int   n_pushed = 0;

    wb_sat_merge_pipe #(.LANES(LANES), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_mask(in_mask), .in_rd(in_rd), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mask(out_mask), .out_rd(out_rd), .out_sat(out_sat),
        .cnt_clr(cnt_clr), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Pops one expectation per output handshake (out_ready is stable from posedge+1).
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 128'(out_rd), 128'h1ff);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_popped++;
                chk("out_data", out_data, e.data);
                chk("out_mask", 128'(out_mask), 128'(e.mask));
                chk("out_rd",   128'(out_rd),   128'(e.rd));
                chk("out_sat",  128'(out_sat),  128'(e.sat));
            end
        end
    end

    // Drive one beat and wait for acceptance; returns cycles spent waiting.
    task automatic send(input logic [1:0] mode, input logic [3:0] mask, input logic [4:0] rd,
                        input logic [127:0] data, input logic [127:0] edata,
                        input logic [3:0] esat, output int waited);
        exp_t e;
        bit   ok;
        in_valid = 1'b1;
        in_mode  = mode;
        in_mask  = mask;
        in_rd    = rd;
        in_data  = data;
        waited   = 0;
        ok       = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            else waited++;
        end
        if (ok) begin
            e.data = edata; e.mask = mask; e.rd = rd; e.sat = esat;
            exp_q.push_back(e);
            n_pushed++;
        end else begin
            chk("accept_timeout", 128'(in_ready), 128'h1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        chk("drain_empty", 128'(exp_q.size()), 128'h0);
    endtask

    initial begin
        int w;
        logic [127:0] a_data;
        rst = 1'b1; in_valid = 0; in_mode = 0; in_mask = 0; in_rd = 0; in_data = 0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'h0);
        chk("rst_out_data",  out_data, 128'h0);
        chk("rst_sat_cnt",   128'(sat_cnt), 128'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", 128'(in_ready), 128'h1);

        // Mode 1 clamp to [0,1]
        send(2'd1, 4'hF, 5'd1,
             {32'h7FC00000, 32'h40000000, 32'h3F000000, 32'hBF000000},
             {32'h00000000, 32'h3F800000, 32'h3F000000, 32'h00000000}, 4'b1101, w);
        chk("cnt_after_unit", 128'(sat_cnt), 128'd3);
        // Mode 2 clamp to [-1,1]; exact 1.0 and -0 pass unflagged
        send(2'd2, 4'hF, 5'd2,
             {32'hFF800000, 32'h80000000, 32'h3F800000, 32'hC0000000},
             {32'hBF800000, 32'h80000000, 32'h3F800000, 32'hBF800000}, 4'b1001, w);
        chk("cnt_after_snorm", 128'(sat_cnt), 128'd5);
        // Bypass and reserved modes leave NaN/Inf/large values untouched
        send(2'd0, 4'hF, 5'd3,
             {32'h4B000000, 32'hFF800001, 32'h7F800000, 32'h7FC00000},
             {32'h4B000000, 32'hFF800001, 32'h7F800000, 32'h7FC00000}, 4'b0000, w);
        send(2'd3, 4'hF, 5'd4,
             {32'h3F800001, 32'h42C80000, 32'hC1200000, 32'hFFC00000},
             {32'h3F800001, 32'h42C80000, 32'hC1200000, 32'hFFC00000}, 4'b0000, w);
        chk("cnt_after_bypass", 128'(sat_cnt), 128'd5);
        // Lane mask gating
        send(2'd1, 4'b0101, 5'd5,
             {4{32'h40400000}},
             {32'h00000000, 32'h3F800000, 32'h00000000, 32'h3F800000}, 4'b0101, w);
        chk("cnt_after_mask", 128'(sat_cnt), 128'd7);
        drain();

        cnt_clr = 1'b1; @(posedge clk); #1 cnt_clr = 1'b0;
        chk("cnt_clear", 128'(sat_cnt), 128'd0);

        // Backpressure: beat A held while B waits
        out_ready = 1'b0;
        a_data = {32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001};
        send(2'd0, 4'hF, 5'd10, a_data, a_data, 4'b0, w);
        in_valid = 1'b1; in_mode = 2'd0; in_mask = 4'hF; in_rd = 5'd11;
        in_data = {4{32'h0000000B}};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_in_ready",  128'(in_ready),  128'h0);
            chk("stall_out_valid", 128'(out_valid), 128'h1);
            chk("stall_out_rd",    128'(out_rd),    128'd10);
            chk("stall_out_data",  out_data, a_data);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        send(2'd0, 4'hF, 5'd11, {4{32'h0000000B}}, {4{32'h0000000B}}, 4'b0, w);
        chk("release_wait", 128'(w), 128'd0);
        send(2'd0, 4'hF, 5'd12, {4{32'h0000000C}}, {4{32'h0000000C}}, 4'b0, w);
        chk("stream_wait_c", 128'(w), 128'd0);
        send(2'd0, 4'hF, 5'd13, {4{32'h0000000D}}, {4{32'h0000000D}}, 4'b0, w);
        chk("stream_wait_d", 128'(w), 128'd0);
        send(2'd0, 4'hF, 5'd14, {4{32'h0000000E}}, {4{32'h0000000E}}, 4'b0, w);
        chk("stream_wait_e", 128'(w), 128'd0);
        drain();
        chk("no_loss_dup", 128'(n_popped), 128'(n_pushed));

        // Counter saturation at 15 with CNT_W=4
        for (int b = 0; b < 5; b++)
            send(2'd1, 4'hF, 5'(20 + b), {4{32'h40000000}}, {4{32'h3F800000}}, 4'hF, w);
        chk("cnt_saturated", 128'(sat_cnt), 128'd15);
        cnt_clr = 1'b1;
        send(2'd1, 4'hF, 5'd25, {4{32'h40000000}}, {4{32'h3F800000}}, 4'hF, w);
        cnt_clr = 1'b0;
        chk("cnt_clr_priority", 128'(sat_cnt), 128'd0);
        drain();

        // Asynchronous reset while stalled
        out_ready = 1'b0;
        send(2'd1, 4'hF, 5'd26, {4{32'h40000000}}, {4{32'h3F800000}}, 4'hF, w);
        chk("pre_rst_cnt", 128'(sat_cnt), 128'd4);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'h0);
        chk("arst_out_data",  out_data, 128'h0);
        chk("arst_out_mask",  128'(out_mask), 128'h0);
        chk("arst_out_rd",    128'(out_rd), 128'h0);
        chk("arst_out_sat",   128'(out_sat), 128'h0);
        chk("arst_sat_cnt",   128'(sat_cnt), 128'h0);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        chk("post_rst_in_ready", 128'(in_ready), 128'h1);
        repeat (2) @(posedge clk);
        #1 chk("post_rst_idle", 128'(out_valid), 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
